uart_rx: RTL and testbench

Serial receiver that sits directly upstream of the authentication block. It deserializes 8N1 UART frames arriving on RX (from the phone/BLE module, or from uart_tx in benches) and presents each byte with a ready flag. The authentication block reads rx_data when rdy is high and acknowledges with clr_rdy. The baud timing must match the transmitter so the two loop back cleanly.

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its consumer (the
// authentication block). The receiver side uses the slave modport and the
// consumer side uses the master modport.
//
// Handshake: rdy is high while rx_data holds a byte that has not been
// consumed. The consumer reads rx_data while rdy is high and pulses
// clr_rdy to acknowledge. rx_data is stable for as long as rdy is high.
// A new start bit also drops rdy. If clr_rdy and a frame completion land
// in the same cycle, rdy ends up set.
interface uart_rx_if;
   logic       RX;          // serial line, idles high
   logic       clr_rdy;     // consumer acknowledge
   logic [7:0] rx_data;     // last good byte
   logic       rdy;         // unconsumed byte present
   logic       frm_err;     // last frame had a low stop bit
   logic [1:0] dbg_state;   // receiver FSM state, for observation
   logic [8:0] dbg_shift;   // receiver shift register, for observation

   modport master (
      output RX, clr_rdy,
      input  rx_data, rdy, frm_err, dbg_state, dbg_shift
   );

   modport slave (
      input  RX, clr_rdy,
      output rx_data, rdy, frm_err, dbg_state, dbg_shift
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. RX is brought into the clock domain by a two-flop
// synchronizer. A start edge arms a half-bit down-counter so that every
// later sample lands in the middle of a bit. There are 10 samples in all:
// the start bit, d0..d7 (LSB first), and the stop bit. A good stop bit
// latches the byte and raises rdy. A low stop bit raises frm_err, and the
// receiver then refuses new starts until the line has been seen high again.
module uart_rx #(
   parameter int BAUD_DIV = 5208
) (
   input  logic clk,
   input  logic rst_n,
   uart_rx_if.slave bus
);

   localparam int CW = $clog2(BAUD_DIV) + 1;
   localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2);
   // The reload value is one less than BAUD_DIV because the zero cycle
   // itself counts as one. This keeps consecutive samples exactly
   // BAUD_DIV clocks apart, so there is no drift across the frame.
   localparam logic [CW-1:0] C_FULL = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RECEIVE = 2'd1
   } state_t;

   state_t        r_state;
   logic          r_rx_meta;
   logic          r_rx_s;
   logic [CW-1:0] r_baud_cnt;
   logic [3:0]    r_bit_cnt;
   logic [8:0]    r_shift;
   logic [7:0]    r_rx_data;
   logic          r_rdy;
   logic          r_frm_err;
   logic          r_hold;      // set after a framing error until the line goes high again
   logic          w_sample;

   assign w_sample = (r_baud_cnt == '0);

   // Two-flop synchronizer, preset to the idle-high level on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= bus.RX;
         r_rx_s    <= r_rx_meta;
      end
   end

   // Receive FSM: start detect, mid-bit sampling, byte latch, and the rdy/frm_err flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= 4'd0;
         r_shift    <= 9'd0;
         r_rx_data  <= 8'h00;
         r_rdy      <= 1'b0;
         r_frm_err  <= 1'b0;
         r_hold     <= 1'b0;
      end else begin
         // An acknowledge clears rdy. A completing frame below overrides
         // this, so a set in the same cycle wins.
         if (bus.clr_rdy) begin
            r_rdy <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (r_hold) begin
                  if (r_rx_s) begin
                     r_hold <= 1'b0;
                  end
               end else if (!r_rx_s) begin
                  r_state    <= S_RECEIVE;
                  r_baud_cnt <= C_HALF;
                  r_bit_cnt  <= 4'd0;
                  r_rdy      <= 1'b0;
                  r_frm_err  <= 1'b0;
               end
            end
            S_RECEIVE: begin
               if (w_sample) begin
                  r_baud_cnt <= C_FULL;
                  r_bit_cnt  <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd0) begin
                     // A start bit that is high again at mid-bit was a glitch
                     if (r_rx_s) begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_shift <= {r_rx_s, r_shift[8:1]};
                     if (r_bit_cnt == 4'd9) begin
                        r_state <= S_IDLE;
                        if (r_rx_s) begin
                           // d7..d0 sit in r_shift[8:1] before the stop bit shifts in
                           r_rx_data <= r_shift[8:1];
                           r_rdy     <= 1'b1;
                        end else begin
                           r_frm_err <= 1'b1;
                           r_hold    <= 1'b1;
                        end
                     end
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - C_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rx_data   = r_rx_data;
   assign bus.rdy       = r_rdy;
   assign bus.frm_err   = r_frm_err;
   assign bus.dbg_state = r_state;
   assign bus.dbg_shift = r_shift;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_DIV=16. Frames are bit-banged onto
// RX. Each good byte goes into exp_q when its frame starts. A monitor pops
// exp_q on every rising edge of rdy and compares rx_data against it.
module tb_uart_rx;

   localparam int D = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   uart_rx_if bus_if ();

   uart_rx #(.BAUD_DIV(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q[$];
   int         n_rdy   = 0;
   int         t_start = 0;
   int         t_rdy   = 0;
   logic       prev_rdy = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one frame: start bit, 8 data bits LSB first, then the given stop level
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic expect_out);
      logic [9:0] bits;
      bits    = {stop, d, 1'b0};
      t_start = cyc;
      if (expect_out) exp_q.push_back(d);
      for (int i = 0; i < 10; i++) begin
         bus_if.RX = bits[i];
         repeat (D) @(negedge clk);
      end
   endtask

   // Wait (bounded) until every expected byte has been delivered
   task automatic drain(input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_q", exp_q.size(), 0);
   endtask

   // Scoreboard monitor: compare the byte on each rising edge of rdy
   always @(negedge clk) begin
      if (rst_n && bus_if.rdy && !prev_rdy) begin
         n_rdy++;
         t_rdy = cyc;
         tests_run++;
         assert (exp_q.size() != 0) else begin
            tests_failed++;
            $error("FAIL spurious_rdy: observed rx_data 0x%0h expected no output", bus_if.rx_data);
         end
         if (exp_q.size() != 0) begin
            check("rx_data", bus_if.rx_data, exp_q.pop_front());
            check("frm_err_at_rdy", bus_if.frm_err, 0);
         end
      end
      prev_rdy = bus_if.rdy;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int big_l;
      int n0;

      bus_if.RX      = 1'b1;
      bus_if.clr_rdy = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rdy",     bus_if.rdy, 0);
      check("reset_frm_err", bus_if.frm_err, 0);
      check("reset_rx_data", bus_if.rx_data, 8'h00);
      check("reset_state",   bus_if.dbg_state, 2'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single byte, latency, then acknowledge
      n0 = n_rdy;
      send_frame(8'h47, 1'b1, 1'b1);
      drain(50);
      check("g_rdy_count", n_rdy - n0, 1);
      lat = t_rdy - t_start;
      tests_run++;
      assert (lat >= 154 && lat <= 156) else begin
         tests_failed++;
         $error("FAIL latency: observed %0d expected 154..156", lat);
      end
      big_l = (lat >= 154 && lat <= 156) ? lat : 156;
      check("g_rdy_high", bus_if.rdy, 1);
      bus_if.clr_rdy = 1'b1;
      @(negedge clk);
      bus_if.clr_rdy = 1'b0;
      check("clr_rdy_low", bus_if.rdy, 0);
      check("clr_data_hold", bus_if.rx_data, 8'h47);

      // Back-to-back frames with no idle between them
      n0 = n_rdy;
      send_frame(8'h53, 1'b1, 1'b1);
      send_frame(8'h47, 1'b1, 1'b1);
      drain(50);
      check("b2b_rdy_count", n_rdy - n0, 2);
      bus_if.clr_rdy = 1'b1;
      @(negedge clk);
      bus_if.clr_rdy = 1'b0;

      // Start glitch shorter than half a bit
      n0 = n_rdy;
      bus_if.RX = 1'b0;
      repeat (4) @(negedge clk);
      bus_if.RX = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_rdy",     bus_if.rdy, 0);
      check("glitch_data",    bus_if.rx_data, 8'h47);
      check("glitch_frm_err", bus_if.frm_err, 0);
      check("glitch_state",   bus_if.dbg_state, 2'd0);
      check("glitch_no_out",  n_rdy - n0, 0);

      // Framing error, line held low afterwards, then a good frame
      n0 = n_rdy;
      send_frame(8'hA5, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      check("ferr_no_false_start", bus_if.dbg_state, 2'd0);
      check("ferr_flag", bus_if.frm_err, 1);
      check("ferr_rdy",  bus_if.rdy, 0);
      check("ferr_data", bus_if.rx_data, 8'h47);
      bus_if.RX = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'h3C, 1'b1, 1'b1);
      drain(50);
      check("ferr_recover_count", n_rdy - n0, 1);
      check("ferr_recover_err",   bus_if.frm_err, 0);
      check("ferr_recover_rdy",   bus_if.rdy, 1);
      check("ferr_recover_data",  bus_if.rx_data, 8'h3C);
      bus_if.clr_rdy = 1'b1;
      @(negedge clk);
      bus_if.clr_rdy = 1'b0;
      repeat (2) @(negedge clk);

      // clr_rdy lands in the completion cycle of the frame: set must win
      fork
         send_frame(8'hFF, 1'b1, 1'b1);
         begin
            repeat (big_l - 1) @(negedge clk);
            bus_if.clr_rdy = 1'b1;
            @(negedge clk);
            bus_if.clr_rdy = 1'b0;
         end
      join
      drain(50);
      check("collide_rdy",  bus_if.rdy, 1);
      check("collide_data", bus_if.rx_data, 8'hFF);

      // Reset in the middle of data bit 4 of a frame
      fork
         send_frame(8'h00, 1'b1, 1'b0);
         begin
            repeat (5 * D + D / 2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midrst_rdy",     bus_if.rdy, 0);
            check("midrst_data",    bus_if.rx_data, 8'h00);
            check("midrst_frm_err", bus_if.frm_err, 0);
            check("midrst_state",   bus_if.dbg_state, 2'd0);
         end
      join
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n0 = n_rdy;
      send_frame(8'h47, 1'b1, 1'b1);
      drain(50);
      check("postrst_count",   n_rdy - n0, 1);
      check("postrst_data",    bus_if.rx_data, 8'h47);
      check("postrst_frm_err", bus_if.frm_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
